// File: rtl/branch_pkg.sv
// Shared types and default widths for the branch controller slice.
package branch_pkg;

    localparam int unsigned PC_W  = 12;  // program-counter / target width
    localparam int unsigned OFF_W = 8;   // signed relative offset width
    localparam int unsigned IDX_W = 4;   // LUT index width
    localparam int unsigned STK_N = 4;   // return-stack depth

    typedef enum logic [2:0] {
        NONE = 3'd0,
        BEQZ = 3'd1,
        BNEZ = 3'd2,
        JMP  = 3'd3,
        CALL = 3'd4,
        RET  = 3'd5,
        HALT = 3'd6
    } br_op_e;

endpackage

// File: rtl/ret_stack.sv
// Call/return address stack; push and pop are never asserted together.
module ret_stack #(
    parameter int unsigned D = 12,
    parameter int unsigned S = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [D-1:0] push_data,
    output logic [D-1:0] top,
    output logic         full,
    output logic         empty
);

    localparam int unsigned SPW = $clog2(S + 1);
    localparam int unsigned IW  = $clog2(S);

    logic [SPW-1:0] sp_q;
    logic [SPW-1:0] sp_d;
    logic [D-1:0]   mem_q [S];

    assign full  = (sp_q == SPW'(S));
    assign empty = (sp_q == '0);
    // Top is only meaningful when not empty.
    assign top   = mem_q[IW'(sp_q - SPW'(1))];

    // Stack-pointer next state.
    always_comb begin
        sp_d = sp_q;
        if (push && !full) begin
            sp_d = sp_q + SPW'(1);
        end else if (pop && !empty) begin
            sp_d = sp_q - SPW'(1);
        end
    end

    // Stack pointer register; contents are discarded by resetting sp.
    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Entry storage written on push.
    always_ff @(posedge clk) begin
        if (!reset && push && !full) begin
            mem_q[IW'(sp_q)] <= push_data;
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// Drives PC control (relative/absolute jump, target, Done) from the decoded branch field.
import branch_pkg::*;

module branch_ctrl #(
    parameter int unsigned D = PC_W,
    parameter int unsigned O = OFF_W,
    parameter int unsigned L = IDX_W,
    parameter int unsigned S = STK_N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [D-1:0] prog_ctr,
    input  logic [2:0]   br_op,
    input  logic [O-1:0] offset,
    input  logic [L-1:0] lut_idx,
    input  logic         zero_flag,
    input  logic         lut_we,
    input  logic [L-1:0] lut_waddr,
    input  logic [D-1:0] lut_wdata,
    output logic         reljump_en,
    output logic         absjump_en,
    output logic [D-1:0] target,
    output logic         Done,
    output logic         stack_ovf,
    output logic         stack_unf
);

    localparam int unsigned LUT_N = 2 ** L;

    logic [D-1:0] lut_q [LUT_N];
    logic         done_q, done_d;
    logic         ovf_q, ovf_d;
    logic         unf_q, unf_d;

    logic         push, pop;
    logic         stk_full, stk_empty;
    logic [D-1:0] stk_top;
    logic [D-1:0] off_sext;
    logic [D-1:0] ret_addr;

    logic         halt_now, fault_now, ovf_set, unf_set, done_c;

    assign off_sext = {{(D - O){offset[O-1]}}, offset};
    assign ret_addr = prog_ctr + D'(1);

    ret_stack #(.D(D), .S(S)) u_stack (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .push_data(ret_addr),
        .top      (stk_top),
        .full     (stk_full),
        .empty    (stk_empty)
    );

    // Output mux, fault detection and Done; everything forced low in reset or once done.
    always_comb begin
        reljump_en = 1'b0;
        absjump_en = 1'b0;
        target     = '0;
        push       = 1'b0;
        pop        = 1'b0;
        halt_now   = 1'b0;
        fault_now  = 1'b0;
        ovf_set    = 1'b0;
        unf_set    = 1'b0;

        case (br_op_e'(br_op))
            BEQZ: begin
                reljump_en = zero_flag;
                target     = off_sext;
            end
            BNEZ: begin
                reljump_en = !zero_flag;
                target     = off_sext;
            end
            JMP: begin
                absjump_en = 1'b1;
                target     = lut_q[lut_idx];
            end
            CALL: begin
                if (stk_full) begin
                    fault_now = 1'b1;
                    ovf_set   = !done_q;
                end else begin
                    absjump_en = 1'b1;
                    target     = lut_q[lut_idx];
                    push       = 1'b1;
                end
            end
            RET: begin
                if (stk_empty) begin
                    fault_now = 1'b1;
                    unf_set   = !done_q;
                end else begin
                    absjump_en = 1'b1;
                    target     = stk_top;
                    pop        = 1'b1;
                end
            end
            HALT:    halt_now = 1'b1;
            default: ;
        endcase

        done_c = done_q || halt_now || fault_now;
        done_d = done_c;
        ovf_d  = ovf_q || ovf_set;
        unf_d  = unf_q || unf_set;

        // Once done the PC holds and the stack is frozen.
        if (done_c || reset) begin
            reljump_en = 1'b0;
            absjump_en = 1'b0;
            target     = '0;
            push       = 1'b0;
            pop        = 1'b0;
        end

        Done      = !reset && done_c;
        stack_ovf = !reset && ovf_d;
        stack_unf = !reset && unf_d;
    end

    // Sticky status flags and the absolute-target LUT (writes accepted even when done).
    always_ff @(posedge clk) begin
        if (reset) begin
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            for (int i = 0; i < LUT_N; i++) begin
                lut_q[i] <= '0;
            end
        end else begin
            done_q <= done_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
            if (lut_we) begin
                lut_q[lut_waddr] <= lut_wdata;
            end
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl with a queue/array reference model checked every cycle.
module tb_branch_ctrl;
    import branch_pkg::*;

    localparam int unsigned D = 12;
    localparam int unsigned O = 8;
    localparam int unsigned L = 4;
    localparam int unsigned S = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [D-1:0] prog_ctr;
    logic [2:0]   br_op;
    logic [O-1:0] offset;
    logic [L-1:0] lut_idx;
    logic         zero_flag;
    logic         lut_we;
    logic [L-1:0] lut_waddr;
    logic [D-1:0] lut_wdata;
    logic         reljump_en, absjump_en, Done, stack_ovf, stack_unf;
    logic [D-1:0] target;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    branch_ctrl #(.D(D), .O(O), .L(L), .S(S)) dut (
        .clk       (clk),
        .reset     (reset),
        .prog_ctr  (prog_ctr),
        .br_op     (br_op),
        .offset    (offset),
        .lut_idx   (lut_idx),
        .zero_flag (zero_flag),
        .lut_we    (lut_we),
        .lut_waddr (lut_waddr),
        .lut_wdata (lut_wdata),
        .reljump_en(reljump_en),
        .absjump_en(absjump_en),
        .target    (target),
        .Done      (Done),
        .stack_ovf (stack_ovf),
        .stack_unf (stack_unf)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: LUT contents, return stack as a queue, sticky flags.
    int lut_m [16];
    int stk_m [$];
    bit done_m, ovf_m, unf_m;
    int e_rel, e_abs, e_tgt, e_done, e_ovf, e_unf;
    bit call_full, ret_empty;

    // Every negedge: compare against the model, then advance the model to the coming edge.
    always @(negedge clk) begin
        call_full = (br_op == CALL) && (stk_m.size() == S);
        ret_empty = (br_op == RET) && (stk_m.size() == 0);
        e_rel = 0; e_abs = 0; e_tgt = 0; e_done = 0; e_ovf = 0; e_unf = 0;
        if (!reset) begin
            e_done = int'(done_m || br_op == HALT || call_full || ret_empty);
            e_ovf  = int'(ovf_m || (call_full && !done_m));
            e_unf  = int'(unf_m || (ret_empty && !done_m));
            if (e_done == 0) begin
                if (br_op == BEQZ || br_op == BNEZ) begin
                    e_rel = (br_op == BEQZ) ? int'(zero_flag) : int'(!zero_flag);
                    e_tgt = int'($signed(offset)) & 'hFFF;
                end else if (br_op == JMP || br_op == CALL) begin
                    e_abs = 1;
                    e_tgt = lut_m[lut_idx];
                end else if (br_op == RET) begin
                    e_abs = 1;
                    e_tgt = stk_m[stk_m.size() - 1];
                end
            end
        end
        chk("model_rel",  int'(reljump_en), e_rel);
        chk("model_abs",  int'(absjump_en), e_abs);
        chk("model_tgt",  int'(target),     e_tgt);
        chk("model_done", int'(Done),       e_done);
        chk("model_ovf",  int'(stack_ovf),  e_ovf);
        chk("model_unf",  int'(stack_unf),  e_unf);

        if (reset) begin
            foreach (lut_m[i]) lut_m[i] = 0;
            stk_m.delete();
            done_m = 0; ovf_m = 0; unf_m = 0;
        end else begin
            if (!done_m) begin
                if (br_op == HALT) begin
                    done_m = 1;
                end else if (br_op == CALL) begin
                    if (stk_m.size() == S) begin done_m = 1; ovf_m = 1; end
                    else stk_m.push_back((int'(prog_ctr) + 1) & 'hFFF);
                end else if (br_op == RET) begin
                    if (stk_m.size() == 0) begin done_m = 1; unf_m = 1; end
                    else void'(stk_m.pop_back());
                end
            end
            if (lut_we) lut_m[lut_waddr] = int'(lut_wdata);
        end
    end

    // Apply one cycle's inputs just after the edge; returns with outputs settled.
    task automatic drive(input logic r, input br_op_e op, input logic [11:0] pc,
                         input logic [7:0] off, input logic [3:0] idx, input logic zf,
                         input logic we, input logic [3:0] wa, input logic [11:0] wd);
        @(posedge clk);
        #1;
        reset = r; br_op = op; prog_ctr = pc; offset = off; lut_idx = idx;
        zero_flag = zf; lut_we = we; lut_waddr = wa; lut_wdata = wd;
        #2;
    endtask

    task automatic idle(input logic r);
        drive(r, NONE, 12'h000, 8'h00, 4'h0, 1'b0, 1'b0, 4'h0, 12'h000);
    endtask

    initial begin
        reset = 1'b1; br_op = NONE; prog_ctr = '0; offset = '0; lut_idx = '0;
        zero_flag = 1'b0; lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0;

        idle(1'b1);
        idle(1'b1);
        chk("reset_done", int'(Done), 0);
        chk("reset_tgt", int'(target), 0);
        idle(1'b0);

        // Conditional relative branches
        drive(0, BEQZ, 12'h000, 8'hFC, 4'h0, 1'b1, 1'b0, 4'h0, 12'h000);
        chk("beqz_taken_rel", int'(reljump_en), 1);
        chk("beqz_taken_tgt", int'(target), 'hFFC);
        drive(0, BEQZ, 12'h001, 8'hFC, 4'h0, 1'b0, 1'b0, 4'h0, 12'h000);
        chk("beqz_not_rel", int'(reljump_en), 0);
        chk("beqz_not_abs", int'(absjump_en), 0);
        drive(0, BNEZ, 12'h002, 8'h7F, 4'h0, 1'b0, 1'b0, 4'h0, 12'h000);
        chk("bnez_rel", int'(reljump_en), 1);
        chk("bnez_tgt", int'(target), 'h07F);

        // LUT write, jump, same-cycle write/read
        drive(0, NONE, 12'h003, 8'h00, 4'h0, 1'b0, 1'b1, 4'h3, 12'h0A5);
        drive(0, JMP, 12'h004, 8'h00, 4'h3, 1'b0, 1'b0, 4'h0, 12'h000);
        chk("jmp_abs", int'(absjump_en), 1);
        chk("jmp_tgt", int'(target), 'h0A5);
        drive(0, JMP, 12'h005, 8'h00, 4'h3, 1'b0, 1'b1, 4'h3, 12'h111);
        chk("jmp_wr_same_idx", int'(target), 'h0A5);
        drive(0, JMP, 12'h006, 8'h00, 4'h3, 1'b0, 1'b0, 4'h0, 12'h000);
        chk("jmp_after_wr", int'(target), 'h111);

        // Call / return, then return on empty stack
        drive(0, NONE, 12'h007, 8'h00, 4'h0, 1'b0, 1'b1, 4'h1, 12'h100);
        drive(0, CALL, 12'h010, 8'h00, 4'h1, 1'b0, 1'b0, 4'h0, 12'h000);
        chk("call_tgt", int'(target), 'h100);
        drive(0, RET, 12'h100, 8'h00, 4'h0, 1'b0, 1'b0, 4'h0, 12'h000);
        chk("ret_abs", int'(absjump_en), 1);
        chk("ret_tgt", int'(target), 'h011);
        drive(0, RET, 12'h011, 8'h00, 4'h0, 1'b0, 1'b0, 4'h0, 12'h000);
        chk("unf_done", int'(Done), 1);
        chk("unf_flag", int'(stack_unf), 1);
        chk("unf_abs", int'(absjump_en), 0);
        idle(1'b0);
        chk("unf_sticky", int'(stack_unf), 1);
        idle(1'b1);
        idle(1'b0);
        chk("post_reset_done", int'(Done), 0);
        chk("post_reset_unf", int'(stack_unf), 0);
        drive(0, JMP, 12'h000, 8'h00, 4'h3, 1'b0, 1'b0, 4'h0, 12'h000);
        chk("lut_cleared", int'(target), 0);

        // Overflow after S nested calls
        drive(0, NONE, 12'h001, 8'h00, 4'h0, 1'b0, 1'b1, 4'h2, 12'h200);
        for (int i = 0; i < S; i++) begin
            drive(0, CALL, 12'(12'h030 + i), 8'h00, 4'h2, 1'b0, 1'b0, 4'h0, 12'h000);
            chk("nest_call_abs", int'(absjump_en), 1);
        end
        drive(0, CALL, 12'h034, 8'h00, 4'h2, 1'b0, 1'b0, 4'h0, 12'h000);
        chk("ovf_abs", int'(absjump_en), 0);
        chk("ovf_done", int'(Done), 1);
        chk("ovf_flag", int'(stack_ovf), 1);
        drive(0, RET, 12'h035, 8'h00, 4'h0, 1'b0, 1'b0, 4'h0, 12'h000);
        chk("ovf_ret_ignored", int'(absjump_en), 0);
        chk("ovf_done_holds", int'(Done), 1);
        idle(1'b1);
        idle(1'b0);

        // Halt is visible in the same cycle and sticks
        drive(0, HALT, 12'h020, 8'h00, 4'h0, 1'b0, 1'b0, 4'h0, 12'h000);
        chk("halt_done_now", int'(Done), 1);
        for (int i = 0; i < 3; i++) begin
            drive(0, NONE, 12'h020, 8'h00, 4'h0, 1'b0, 1'b1, 4'h5, 12'h055);
            chk("halt_done_sticky", int'(Done), 1);
        end
        idle(1'b1);
        chk("halt_reset_done", int'(Done), 0);
        idle(1'b0);
        chk("halt_after_reset", int'(Done), 0);
        chk("halt_after_ovf", int'(stack_ovf), 0);

        // Reset together with CALL must not push
        drive(1, CALL, 12'h040, 8'h00, 4'h2, 1'b0, 1'b0, 4'h0, 12'h000);
        drive(0, RET, 12'h041, 8'h00, 4'h0, 1'b0, 1'b0, 4'h0, 12'h000);
        chk("rst_call_unf", int'(stack_unf), 1);
        chk("rst_call_abs", int'(absjump_en), 0);
        idle(1'b1);
        idle(1'b0);

        // Return-address wrap and LIFO order
        drive(0, NONE, 12'h000, 8'h00, 4'h0, 1'b0, 1'b1, 4'h4, 12'h400);
        drive(0, CALL, 12'hFFF, 8'h00, 4'h4, 1'b0, 1'b0, 4'h0, 12'h000);
        drive(0, CALL, 12'h060, 8'h00, 4'h4, 1'b0, 1'b0, 4'h0, 12'h000);
        drive(0, RET, 12'h400, 8'h00, 4'h0, 1'b0, 1'b0, 4'h0, 12'h000);
        chk("lifo_inner", int'(target), 'h061);
        drive(0, RET, 12'h061, 8'h00, 4'h0, 1'b0, 1'b0, 4'h0, 12'h000);
        chk("wrap_ret", int'(target), 'h000);
        chk("wrap_abs", int'(absjump_en), 1);
        idle(1'b0);
        idle(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
